// File: rtl/mod_counter_if.sv
// mod_counter_if: control/status bundle between test logic (master) and mod_counter (slave)
interface mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic             up_dn;
    logic             clr_ovf;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (output en, load, up_dn, d_in, clr_ovf, input count, tc, wrap, ovf);
    modport slave (input en, load, up_dn, d_in, clr_ovf, output count, tc, wrap, ovf);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: programmable-modulus loadable up/down counter with tc, wrap pulse and sticky ovf;
// defining MOD_COUNTER_SATURATE_EN makes boundary steps hold instead of wrapping
module mod_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 200
) (
    input logic          clk,
    input logic          rst,
    mod_counter_if.slave bus
);
    localparam logic [WIDTH:0] MAX_V = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] MOD_V = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS %0d outside 2..2^%0d", MODULUS, WIDTH);
    end

    // counter kept one bit wider than the output so MODULUS = 2^WIDTH never relies on rollover
    logic [WIDTH:0] cnt_q;
    logic [WIDTH:0] ld_v;
    logic [WIDTH:0] step;
    logic [WIDTH:0] nxt;
    logic           tc;
    logic           wrap_q;
    logic           ovf_q;

    // boundary detection, clamped load value and next-count selection (load > en > hold)
    always_comb begin
        tc   = bus.en & ~bus.load & (bus.up_dn ? cnt_q == MAX_V : cnt_q == '0);
        ld_v = {1'b0, bus.d_in} < MOD_V ? {1'b0, bus.d_in} : MAX_V;
`ifdef MOD_COUNTER_SATURATE_EN
        step = tc ? cnt_q : (bus.up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1);
`else
        step = tc ? (bus.up_dn ? '0 : MAX_V) : (bus.up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1);
`endif
        nxt  = bus.load ? ld_v : (bus.en ? step : cnt_q);
    end

    // state registers; wrap echoes tc one cycle later, ovf is set by tc and beats clr_ovf
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= nxt;
            wrap_q <= tc;
            ovf_q  <= tc | (ovf_q & ~bus.clr_ovf);
        end
    end

    assign bus.count = cnt_q[WIDTH-1:0];
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;
endmodule
